// File: rtl/spi_poll_reader.sv
// ---------------------------------------------------------------------------
// spi_poll_reader
//
// SPI read master that polls up to N_CH read-only slaves (ADCs, sensors) in
// round-robin order. A transaction starts when a trigger is pending. A
// trigger comes from a free-running refresh timer (while en=1), from a
// one-shot req pulse, or from both. Each transaction shifts in DATA_W bits,
// MSB first. sclk idles high, sdo is sampled on the sclk rising edge, and the
// slave changes sdo on the falling edge.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst_l      asynchronous active-low reset
//   en         refresh-timer enable
//   req        one-shot read request, sampled every clk
//   sdo        serial data from the selected slave
//   sclk       SPI clock, idles high
//   cs_n       active-low chip selects, at most one low at a time
//   data       last completed word, held until the next completion
//   data_ch    channel that data came from
//   data_valid one-cycle pulse when data/data_ch update
//   busy       high from leaving IDLE until re-entering IDLE
//   overrun    one-cycle pulse when a trigger merges into a pending one
// ---------------------------------------------------------------------------
module spi_poll_reader #(
  parameter int DATA_W  = 16,
  parameter int N_CH    = 1,
  parameter int CLK_DIV = 4,
  parameter int REFRESH = 40000,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en,
  input  logic              req,
  input  logic              sdo,
  output logic              sclk,
  output logic [N_CH-1:0]   cs_n,
  output logic [DATA_W-1:0] data,
  output logic [CH_W-1:0]   data_ch,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int TMR_W = $clog2(REFRESH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [CH_W-1:0]   ch;
  logic              pending;

  logic tmr_trig;
  logic trig;
  logic phase_end;
  logic start;

  assign tmr_trig  = en && (timer == TMR_W'(REFRESH - 1));
  // A timer trigger and a req in the same cycle count as a single trigger.
  assign trig      = tmr_trig | req;
  assign phase_end = (cnt == CNT_W'(CLK_DIV - 1));
  // A pending trigger is consumed from IDLE, or directly at the end of GAP.
  // The GAP case keeps back-to-back transactions separated by GAP alone,
  // with no extra IDLE cycle.
  assign start     = pending && ((state == S_IDLE) || ((state == S_GAP) && phase_end));

  // Refresh timer runs independently of the FSM and is held at 0 while disabled.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register in the design updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timer <= '0;
    end else if (!en || tmr_trig) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Pending flag. A trigger that arrives in the consume cycle re-arms it
  // silently. Overrun fires only when a trigger lands on an unconsumed
  // pending flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (start) begin
      pending <= trig;
      overrun <= 1'b0;
    end else begin
      pending <= pending | trig;
      overrun <= trig & pending;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ch         <= '0;
      sclk       <= 1'b1;
      cs_n       <= '1;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= S_SETUP;
            cs_n  <= ~(N_CH'(1) << ch);
            busy  <= 1'b1;
          end
        end

        S_SETUP: begin
          if (phase_end) begin
            state   <= S_SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Each bit has a low phase then a high phase. sdo is captured on
        // the edge that raises sclk.
        S_SHIFT: begin
          if (phase_end) begin
            cnt <= '0;
            if (!sclk) begin
              sclk    <= 1'b1;
              shreg   <= DATA_W'({shreg, sdo});
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == BIT_W'(DATA_W)) begin
              state      <= S_HOLD;
              data       <= shreg;
              data_ch    <= ch;
              data_valid <= 1'b1;
            end else begin
              sclk <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (phase_end) begin
            state <= S_GAP;
            cnt   <= '0;
            cs_n  <= '1;
            ch    <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (phase_end) begin
            cnt <= '0;
            if (start) begin
              state <= S_SETUP;
              cs_n  <= ~(N_CH'(1) << ch);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          sclk  <= 1'b1;
          cs_n  <= '1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_poll_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_poll_reader
//
// Two instances share clk and rst_l:
//   dut_a  DATA_W=16, N_CH=2, CLK_DIV=2, REFRESH=200  (most scenarios)
//   dut_b  same, but REFRESH=50                      (back-to-back/overrun)
// Each instance has a slave model that loads a word when its chip select
// falls and shifts the word out MSB first on sclk falling edges.
// For dut_a, a scoreboard checks every completed word against the word its
// slave actually sent and against a round-robin channel model.
// ---------------------------------------------------------------------------
module tb_spi_poll_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l;

  logic        en_a, req_a, sdo_a, sclk_a, dv_a, busy_a, ov_a;
  logic [1:0]  cs_a;
  logic [15:0] data_a;
  logic [0:0]  dch_a;

  logic        en_b, req_b, sdo_b, sclk_b, dv_b, busy_b, ov_b;
  logic [1:0]  cs_b;
  logic [15:0] data_b;
  logic [0:0]  dch_b;

  spi_poll_reader #(.DATA_W(16), .N_CH(2), .CLK_DIV(2), .REFRESH(200)) dut_a (
    .clk(clk), .rst_l(rst_l), .en(en_a), .req(req_a), .sdo(sdo_a),
    .sclk(sclk_a), .cs_n(cs_a), .data(data_a), .data_ch(dch_a),
    .data_valid(dv_a), .busy(busy_a), .overrun(ov_a));

  spi_poll_reader #(.DATA_W(16), .N_CH(2), .CLK_DIV(2), .REFRESH(50)) dut_b (
    .clk(clk), .rst_l(rst_l), .en(en_b), .req(req_b), .sdo(sdo_b),
    .sclk(sclk_b), .cs_n(cs_b), .data(data_b), .data_ch(dch_b),
    .data_valid(dv_b), .busy(busy_b), .overrun(ov_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave models ----------------
  typedef struct {
    int          ch;
    logic [15:0] word;
  } xfer_t;

  logic [15:0] word_a [2];
  logic [15:0] word_b [2];
  bit          rand_mode = 1'b0;
  xfer_t       exp_q_a [$];

  logic [15:0] cur_a, cur_b;
  int          pos_a, pos_b, sel_a, sel_b;
  wire         idle_a = &cs_a;
  wire         idle_b = &cs_b;

  initial begin
    sdo_a = 1'b0;
    sdo_b = 1'b0;
  end

  // sclk is high when the select falls and low on a shift edge.
  always @(negedge sclk_a or negedge idle_a) begin
    if (!idle_a) begin
      if (sclk_a) begin
        sel_a = cs_a[0] ? 1 : 0;
        cur_a = rand_mode ? 16'($urandom) : word_a[sel_a];
        pos_a = 16;
        exp_q_a.push_back('{sel_a, cur_a});
      end else if (pos_a > 0) begin
        pos_a--;
        sdo_a = cur_a[pos_a];
      end
    end
  end

  always @(negedge sclk_b or negedge idle_b) begin
    if (!idle_b) begin
      if (sclk_b) begin
        sel_b = cs_b[0] ? 1 : 0;
        cur_b = word_b[sel_b];
        pos_b = 16;
      end else if (pos_b > 0) begin
        pos_b--;
        sdo_b = cur_b[pos_b];
      end
    end
  end

  // ---------------- monitors ----------------
  int          sclk_rise_a = 0;
  always @(posedge sclk_a) sclk_rise_a++;

  logic [1:0]  cs_prev_a = 2'b11;
  int          falls_a = 0, dv_cnt_a = 0, ov_cnt_a = 0, busy_cyc_a = 0, cs_err = 0;
  int          sb_ch_a = 0;
  int          fall_cyc_a [$];
  logic [1:0]  fall_pat_a [$];
  logic [15:0] dv_data_a [$];
  int          dv_ch_a [$];
  xfer_t       x_a;

  always @(negedge clk) begin
    if (!rst_l) begin
      exp_q_a.delete();
      sb_ch_a = 0;
    end
    if (cs_a != 2'b11 && cs_prev_a == 2'b11) begin
      falls_a++;
      fall_cyc_a.push_back(cyc);
      fall_pat_a.push_back(cs_a);
    end
    if (cs_a == 2'b00 || cs_b == 2'b00) cs_err++;
    cs_prev_a = cs_a;
    if (busy_a) busy_cyc_a++;
    if (ov_a) ov_cnt_a++;
    if (dv_a) begin
      dv_cnt_a++;
      dv_data_a.push_back(data_a);
      dv_ch_a.push_back(int'(dch_a));
      if (exp_q_a.size() == 0) begin
        check("sb_a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        x_a = exp_q_a.pop_front();
        check("sb_a_data", data_a, x_a.word);
        check("sb_a_data_ch", dch_a, sb_ch_a);
        check("sb_a_cs_channel", x_a.ch, sb_ch_a);
      end
      sb_ch_a = (sb_ch_a + 1) % 2;
    end
  end

  logic [1:0] cs_prev_b = 2'b11;
  int         dv_cnt_b = 0, ov_cnt_b = 0, sb_ch_b = 0;
  int         rise_cyc_b = 0, gap_min_b = 1000, gap_max_b = 0, gap_n_b = 0;
  bit         have_rise_b = 1'b0;

  always @(negedge clk) begin
    if (!rst_l) sb_ch_b = 0;
    if (cs_b != 2'b11 && cs_prev_b == 2'b11 && have_rise_b) begin
      gap_n_b++;
      if (cyc - rise_cyc_b < gap_min_b) gap_min_b = cyc - rise_cyc_b;
      if (cyc - rise_cyc_b > gap_max_b) gap_max_b = cyc - rise_cyc_b;
    end
    if (cs_b == 2'b11 && cs_prev_b != 2'b11) begin
      have_rise_b = 1'b1;
      rise_cyc_b  = cyc;
    end
    cs_prev_b = cs_b;
    if (ov_b) ov_cnt_b++;
    if (dv_b) begin
      dv_cnt_b++;
      check("b_data", data_b, word_b[sb_ch_b]);
      check("b_data_ch", dch_b, sb_ch_b);
      sb_ch_b = (sb_ch_b + 1) % 2;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_dv_a(input int target, input int max_cyc, input string name);
    int n = 0;
    while (dv_cnt_a < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (dv_cnt_a < target) check(name, dv_cnt_a, target);
  endtask

  task automatic wait_idle_a(input int max_cyc, input string name);
    int n = 0;
    @(negedge clk);
    while (busy_a && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) check(name, busy_a, 32'd0);
  endtask

  task automatic pulse_req_a();
    @(posedge clk);
    #1 req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_l = 1'b1;
  endtask

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_data;
    logic        exp_ch;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    int s_rise, s_busy, s_dv, s_fall, s_ov, changes, n;

    vecs[0] = '{16'h1111, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{16'hFFFF, 16'h2222, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h3333, 16'h8000, 16'h8000, 1'b1};
    vecs[3] = '{16'h0001, 16'h4444, 16'h0001, 1'b0};
    vecs[4] = '{16'h5555, 16'h7FFE, 16'h7FFE, 1'b1};
    vecs[5] = '{16'hDEAD, 16'h6666, 16'hDEAD, 1'b0};

    rst_l = 1'b0;
    en_a = 1'b0; req_a = 1'b0; en_b = 1'b0; req_b = 1'b0;
    word_a[0] = 16'h0000; word_a[1] = 16'h0000;
    word_b[0] = 16'h5A0F; word_b[1] = 16'hC3E1;

    // Reset values while clk toggles
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk_a, 32'd1);
    check("rst_cs_n", cs_a, 32'h3);
    check("rst_data", data_a, 32'h0);
    check("rst_data_valid", dv_a, 32'd0);
    check("rst_busy", busy_a, 32'd0);
    check("rst_overrun", ov_a, 32'd0);
    #2 rst_l = 1'b1;

    changes = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sclk_a !== 1'b1 || cs_a !== 2'b11 || busy_a !== 1'b0 || dv_a !== 1'b0 ||
          data_a !== 16'h0 || ov_a !== 1'b0) changes++;
    end
    check("idle_500_stable", changes, 32'd0);

    // Single req read from ch0
    word_a[0] = 16'hA5C3;
    s_rise = sclk_rise_a; s_busy = busy_cyc_a; s_dv = dv_cnt_a;
    pulse_req_a();
    n = 0;
    while (cs_a == 2'b11 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_cs_n", cs_a, 32'h2);
    wait_dv_a(s_dv + 1, 200, "req_dv_timeout");
    wait_idle_a(200, "req_idle_timeout");
    check("req_sclk_rises", sclk_rise_a - s_rise, 32'd16);
    check("req_busy_cycles", busy_cyc_a - s_busy, 32'd70);
    check("req_dv_pulses", dv_cnt_a - s_dv, 32'd1);
    check("req_data", data_a, 32'hA5C3);
    check("req_data_ch", dch_a, 32'd0);

    // Table of req-driven reads; the channel pointer alternates
    foreach (vecs[i]) begin
      word_a[0] = vecs[i].w0;
      word_a[1] = vecs[i].w1;
      s_dv = dv_cnt_a;
      pulse_req_a();
      wait_dv_a(s_dv + 1, 200, "vec_dv_timeout");
      wait_idle_a(200, "vec_idle_timeout");
      check($sformatf("vec%0d_data", i), data_a, vecs[i].exp_data);
      check($sformatf("vec%0d_ch", i), dch_a, vecs[i].exp_ch);
    end

    // Requests while busy: the second queues silently, the third overruns
    s_dv = dv_cnt_a; s_ov = ov_cnt_a;
    pulse_req_a();
    repeat (10) @(posedge clk);
    pulse_req_a();
    repeat (5) @(posedge clk);
    pulse_req_a();
    wait_dv_a(s_dv + 2, 300, "merge_dv_timeout");
    wait_idle_a(200, "merge_idle_timeout");
    check("merge_transactions", dv_cnt_a - s_dv, 32'd2);
    check("merge_overruns", ov_cnt_a - s_ov, 32'd1);

    // Async reset after 7 bits of a transaction; no partial word published
    word_a[0] = 16'h9C6B;
    do_reset();
    pulse_req_a();
    n = 0;
    while (cs_a == 2'b11 && n < 10) begin
      @(negedge clk);
      n++;
    end
    s_rise = sclk_rise_a;
    n = 0;
    while (sclk_rise_a < s_rise + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_bit7", sclk_rise_a - s_rise, 32'd7);
    s_dv = dv_cnt_a;
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    check("abort_sclk", sclk_a, 32'd1);
    check("abort_cs_n", cs_a, 32'h3);
    check("abort_busy", busy_a, 32'd0);
    check("abort_data", data_a, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_l = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_valid", dv_cnt_a - s_dv, 32'd0);
    s_rise = sclk_rise_a;
    pulse_req_a();
    wait_dv_a(s_dv + 1, 200, "abort_dv_timeout");
    wait_idle_a(200, "abort_idle_timeout");
    check("abort_next_data", data_a, 32'h9C6B);
    check("abort_next_ch", dch_a, 32'd0);
    check("abort_next_rises", sclk_rise_a - s_rise, 32'd16);

    // Timer polling: ch0, ch1, ch0, 200 cycles apart, no overrun
    do_reset();
    word_a[0] = 16'h1234; word_a[1] = 16'hBEEF;
    s_fall = falls_a; s_dv = dv_cnt_a; s_ov = ov_cnt_a;
    @(posedge clk);
    #1 en_a = 1'b1;
    wait_dv_a(s_dv + 3, 900, "poll_dv_timeout");
    en_a = 1'b0;
    wait_idle_a(200, "poll_idle_timeout");
    if (dv_cnt_a >= s_dv + 3 && falls_a >= s_fall + 3) begin
      check("poll_data0", dv_data_a[s_dv], 32'h1234);
      check("poll_data1", dv_data_a[s_dv + 1], 32'hBEEF);
      check("poll_data2", dv_data_a[s_dv + 2], 32'h1234);
      check("poll_ch0", dv_ch_a[s_dv], 32'd0);
      check("poll_ch1", dv_ch_a[s_dv + 1], 32'd1);
      check("poll_ch2", dv_ch_a[s_dv + 2], 32'd0);
      check("poll_cs0", fall_pat_a[s_fall], 32'h2);
      check("poll_cs1", fall_pat_a[s_fall + 1], 32'h1);
      check("poll_cs2", fall_pat_a[s_fall + 2], 32'h2);
      check("poll_period01", fall_cyc_a[s_fall + 1] - fall_cyc_a[s_fall], 32'd200);
      check("poll_period12", fall_cyc_a[s_fall + 2] - fall_cyc_a[s_fall + 1], 32'd200);
    end else begin
      check("poll_event_count", dv_cnt_a - s_dv, 32'd3);
    end
    check("poll_no_overrun", ov_cnt_a - s_ov, 32'd0);

    // req in the same cycle as the timer trigger counts once
    s_fall = falls_a; s_dv = dv_cnt_a; s_ov = ov_cnt_a;
    @(posedge clk);
    #1 en_a = 1'b1;
    repeat (199) @(posedge clk);
    #1 req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    wait_dv_a(s_dv + 1, 200, "coinc_dv_timeout");
    repeat (100) @(negedge clk);
    en_a = 1'b0;
    wait_idle_a(200, "coinc_idle_timeout");
    check("coinc_transactions", falls_a - s_fall, 32'd1);
    check("coinc_valids", dv_cnt_a - s_dv, 32'd1);
    check("coinc_no_overrun", ov_cnt_a - s_ov, 32'd0);

    // REFRESH shorter than a transaction: back-to-back, overrun, 2-cycle gap
    s_ov = ov_cnt_b;
    @(posedge clk);
    #1 en_b = 1'b1;
    n = 0;
    while (dv_cnt_b < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("fast_valids", (dv_cnt_b >= 6), 32'd1);
    en_b = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy_b && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("fast_idle", busy_b, 32'd0);
    check("fast_overrun_seen", (ov_cnt_b - s_ov > 0), 32'd1);
    check("fast_gaps_seen", (gap_n_b >= 5), 32'd1);
    check("fast_gap_min", gap_min_b, 32'd2);
    check("fast_gap_max", gap_max_b, 32'd2);

    // Randomized requests and enable toggling against the scoreboard
    rand_mode = 1'b1;
    s_fall = falls_a; s_dv = dv_cnt_a;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      req_a = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 399) == 0) en_a = ~en_a;
    end
    #1 req_a = 1'b0;
    en_a = 1'b0;
    for (int k = 0; k < 3; k++) wait_idle_a(300, "rand_idle_timeout");
    check("rand_activity", (dv_cnt_a - s_dv > 10), 32'd1);
    check("rand_valid_per_select", dv_cnt_a - s_dv, falls_a - s_fall);
    check("rand_queue_empty", exp_q_a.size(), 32'd0);
    check("cs_n_single_low", cs_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
